ibexc_dmem_responder: RTL
=========================

// Module: ibexc_dmem_responder
// PURPOSE
//  Responder (memory side) of the CHERIoT-Ibex data memory interface (req/gnt/rvalid, 33-bit tagged data).
//  Backs a word-addressed tagged SRAM window for simulation/FPGA top levels.
//  Provides fixed response latency, optional grant throttling, and error responses outside the window.
//  Intended to sit directly on the data_* ports of the core top level, opposite the core's LSU.
// PARAMETERS
//  MemBase      32'h2000_0000  byte base address of the window (4-byte aligned)
//  MemWords     16384          window size in 33-bit words (power of 2)
//  RespLatency  1              cycles from grant to rvalid (1..4)
//  MaxOutstanding 2            max granted-but-unanswered requests (>= RespLatency gives full throughput)
//  DataWidth    33             bit 32 = capability tag
// PORTS
//  clk_i              in   1   clock
//  rst_ni             in   1   async active-low reset
//  data_req_i         in   1   request from core
//  data_gnt_o         out  1   request accepted this cycle
//  data_we_i          in   1   1 = write
//  data_be_i          in   4   byte enables
//  data_addr_i        in   32  byte address (word aligned)
//  data_is_cap_i      in   1   capability access (tag meaningful)
//  data_wdata_i       in   33  write data + tag
//  data_rvalid_o      out  1   response valid
//  data_rdata_o       out  33  read data + tag
//  data_rdata_intg_o  out  7   SECDED(39,32) check bits of data_rdata_o[31:0]
//  data_err_o         out  1   error response (qualifies rvalid)
//  gnt_stall_i        in   1   test hook: force data_gnt_o low
// BEHAVIOUR
//  Reset: data_gnt_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0; pipeline/counter cleared; array not reset.
//  Grant: data_gnt_o = data_req_i & ~gnt_stall_i & (outstanding < MaxOutstanding); combinational.
//   Request transfers on req&gnt; core holds req/addr/we/be/wdata stable until gnt.
//  outstanding counter: +1 on grant, -1 on rvalid, both same cycle -> unchanged; never exceeds MaxOutstanding.
//  Response pipeline: shift register of RespLatency stages {valid, err, rdata}; granted request at cycle N
//   produces rvalid exactly at cycle N+RespLatency, one cycle high, in order. No rvalid backpressure.
//  Address decode: in-window iff MemBase <= addr < MemBase+4*MemWords; index = (addr-MemBase)>>2.
//   Out-of-window: no array access, err=1, rdata=0. Top-of-window word in range; next word errors.
//  Write (in-window): bytes with be[i]=1 updated; tag := data_is_cap_i & (be==4'hF) & wdata[32];
//   any non-cap or partial write clears the tag. Write response: rvalid with err=0, rdata=0.
//  Read (in-window): rdata[31:0] = array word sampled at grant cycle (read-after-write of an earlier
//   granted write returns the new value); rdata[32] = stored tag & data_is_cap_i (non-cap reads return tag 0).
//  be==0 read/write: legal, write changes nothing (tag preserved), read returns word.
//  data_rdata_intg_o: combinational encode of data_rdata_o[31:0]; 0 when rvalid=0 (rdata=0 -> encoding of 0).
//  Reset mid-operation: in-flight responses discarded, no rvalid after reset release for pre-reset requests.
//  gnt_stall_i asserted with outstanding requests: pending responses still return on schedule.
// TESTING
//  1) RespLatency=1: write 0x1_DEADBEEF is_cap be=F to MemBase, read is_cap -> rvalid next cycle, rdata=33'h1_DEADBEEF, err=0.
//  2) Tag clear: after (1), write be=4'b0001 data 0x00 non-cap, read is_cap -> rdata=33'h0_DEADBE00; non-cap read of tagged word -> bit32=0.
//  3) Error: read MemBase+4*MemWords and MemBase-4 -> err=1, rdata=0, array unchanged (re-read MemBase matches).
//  4) Throughput: RespLatency=3, MaxOutstanding=3, back-to-back 8 reads -> gnt every cycle, rvalid every cycle from cycle 3, order kept.
//  5) Throttle: MaxOutstanding=1, RespLatency=2 -> gnt at most every 2 cycles; gnt_stall_i=1 for 5 cycles -> no gnt, held req granted after release.
//  6) Reset: assert rst_ni low 1 cycle after grant -> no rvalid for that request, outstanding=0, outputs 0.

Source files
------------

// File: rtl/ibexc_dmem_responder.sv
// Memory-side responder for the CHERIoT-Ibex data interface: tagged word SRAM window,
// fixed-latency in-order responses, outstanding-request throttling and out-of-window errors.
module ibexc_dmem_responder #(
  parameter logic [31:0]  MemBase        = 32'h2000_0000,
  parameter int unsigned  MemWords       = 16384,
  parameter int unsigned  RespLatency    = 1,
  parameter int unsigned  MaxOutstanding = 2,
  parameter int unsigned  DataWidth      = 33
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic                 data_is_cap_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic [6:0]           data_rdata_intg_o,
  output logic                 data_err_o,
  input  logic                 gnt_stall_i
);

  localparam int unsigned IdxW   = $clog2(MemWords);
  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned TagBit = DataWidth - 1;
  localparam logic [32:0] WinBytes = 33'(MemWords) << 2;
  localparam logic [31:0] IntgMask [7] = '{
    32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA, 32'h3123_4ED1,
    32'hC2C1_323B, 32'h2DCC_624C, 32'h9850_5586
  };

  logic [DataWidth-1:0]   mem_q [MemWords];
  logic [CntW-1:0]        outstanding_q, outstanding_d, outstanding_eff;
  logic [RespLatency-1:0] valid_q, err_q;
  logic [DataWidth-1:0]   rdata_q [RespLatency];

  logic [31:0]            offset;
  logic                   in_win;
  logic [IdxW-1:0]        idx;
  logic [DataWidth-1:0]   rd_word, rdata_s0;
  logic                   gnt;

  // Address decode; addresses below the base wrap to a huge offset and fall out of window.
  assign offset = data_addr_i - MemBase;
  assign in_win = (33'(offset) < WinBytes);
  assign idx    = offset[IdxW+1:2];

  // A response leaving this cycle frees its slot, so MaxOutstanding >= RespLatency streams.
  assign outstanding_eff = outstanding_q - CntW'(data_rvalid_o);
  assign gnt = rst_ni & data_req_i & ~gnt_stall_i & (outstanding_eff < CntW'(MaxOutstanding));
  assign data_gnt_o = gnt;

  assign outstanding_d = outstanding_q + CntW'(gnt) - CntW'(data_rvalid_o);

  assign rd_word = mem_q[idx];

  always_comb begin
    rdata_s0 = '0;
    if (gnt && in_win && !data_we_i) begin
      rdata_s0 = {rd_word[TagBit] & data_is_cap_i, rd_word[TagBit-1:0]};
    end
  end

  // Tagged array: byte-enabled data update; tag survives only full-word capability writes.
  always_ff @(posedge clk_i) begin
    if (gnt && in_win && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
      if (|data_be_i) begin
        mem_q[idx][TagBit] <= data_is_cap_i & (&data_be_i) & data_wdata_i[TagBit];
      end
    end
  end

  // Response pipeline and outstanding counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      valid_q       <= '0;
      err_q         <= '0;
      for (int i = 0; i < RespLatency; i++) rdata_q[i] <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      valid_q[0]    <= gnt;
      err_q[0]      <= gnt & ~in_win;
      rdata_q[0]    <= rdata_s0;
      for (int i = 1; i < RespLatency; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign data_rvalid_o = valid_q[RespLatency-1];
  assign data_err_o    = err_q[RespLatency-1];
  assign data_rdata_o  = rdata_q[RespLatency-1];

  // SECDED(39,32) check bits of the returned data word.
  always_comb begin
    data_rdata_intg_o = '0;
    if (data_rvalid_o) begin
      for (int j = 0; j < 7; j++) begin
        data_rdata_intg_o[j] = ^(data_rdata_o[31:0] & IntgMask[j]);
      end
    end
  end

endmodule
